// File: rtl/gray_conv_sched_if.sv
// gray_conv_sched_if: two requester ports, response port and busy flag of gray_conv_sched.
// master drives requests and rsp_ready; slave is the scheduler.
interface gray_conv_sched_if #(parameter int WIDTH = 4);
    logic             req0_valid;
    logic             req0_mode;
    logic [WIDTH-1:0] req0_data;
    logic             req0_ready;
    logic             req1_valid;
    logic             req1_mode;
    logic [WIDTH-1:0] req1_data;
    logic             req1_ready;
    logic             rsp_valid;
    logic             rsp_id;
    logic [WIDTH-1:0] rsp_data;
    logic             rsp_ready;
    logic             busy;
    modport master (
        output req0_valid, req0_mode, req0_data, input req0_ready,
        output req1_valid, req1_mode, req1_data, input req1_ready,
        input rsp_valid, rsp_id, rsp_data, output rsp_ready,
        input busy
    );
    modport slave (
        input req0_valid, req0_mode, req0_data, output req0_ready,
        input req1_valid, req1_mode, req1_data, output req1_ready,
        output rsp_valid, rsp_id, rsp_data, input rsp_ready,
        output busy
    );
endinterface

// File: rtl/gray_conv_sched.sv
// gray_conv_sched: round-robin two-requester binary<->Gray converter, one conversion in flight.
// Define GRAY_SCHED_FASTPATH_EN to drop the CONV state and register the result on the accept edge.
module gray_conv_sched #(
    parameter int WIDTH = 4
) (
    input logic clk,
    input logic rst_n,
    gray_conv_sched_if.slave bus
);
    typedef enum logic [1:0] {IDLE, CONV, RESP} state_t;
    state_t           state, state_nxt;
    logic             last_gnt, gnt0, gnt1, take, sel_mode, id_q;
    logic [WIDTH-1:0] sel_data, rsp_data_q;
`ifndef GRAY_SCHED_FASTPATH_EN
    logic             mode_q;
    logic [WIDTH-1:0] data_q;
`endif

    // mode 0: g = b ^ (b >> 1); mode 1: prefix XOR from the MSB down
    function automatic logic [WIDTH-1:0] convert(input logic mode, input logic [WIDTH-1:0] d);
        logic [WIDTH-1:0] b;
        b[WIDTH-1] = d[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) b[i] = mode ? b[i+1] ^ d[i] : d[i+1] ^ d[i];
        return b;
    endfunction

    // last_gnt resets to 1 so requester 0 wins the first contested grant
    always_comb begin
        gnt0     = state == IDLE && rst_n && bus.req0_valid && (!bus.req1_valid || last_gnt);
        gnt1     = state == IDLE && rst_n && bus.req1_valid && !gnt0;
        take     = gnt0 | gnt1;
        sel_mode = gnt1 ? bus.req1_mode : bus.req0_mode;
        sel_data = gnt1 ? bus.req1_data : bus.req0_data;
    end

    always_comb begin
        state_nxt = state;
        case (state)
`ifdef GRAY_SCHED_FASTPATH_EN
            IDLE:    state_nxt = take ? RESP : IDLE;
`else
            IDLE:    state_nxt = take ? CONV : IDLE;
            CONV:    state_nxt = RESP;
`endif
            RESP:    state_nxt = bus.rsp_ready ? IDLE : RESP;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_gnt   <= 1'b1;
            id_q       <= 1'b0;
            rsp_data_q <= '0;
`ifndef GRAY_SCHED_FASTPATH_EN
            mode_q     <= 1'b0;
            data_q     <= '0;
`endif
        end else begin
            state <= state_nxt;
            if (take) begin
                last_gnt <= gnt1;
                id_q     <= gnt1;
`ifdef GRAY_SCHED_FASTPATH_EN
                rsp_data_q <= convert(sel_mode, sel_data);
`else
                mode_q   <= sel_mode;
                data_q   <= sel_data;
`endif
            end
`ifndef GRAY_SCHED_FASTPATH_EN
            if (state == CONV) rsp_data_q <= convert(mode_q, data_q);
`endif
        end
    end

    assign bus.req0_ready = gnt0;
    assign bus.req1_ready = gnt1;
    assign bus.rsp_valid  = state == RESP;
    assign bus.rsp_id     = id_q;
    assign bus.rsp_data   = rsp_data_q;
    assign bus.busy       = state != IDLE;
endmodule

// File: tb/tb_gray_conv_sched.sv
// tb_gray_conv_sched: directed scenarios plus random traffic checked every cycle
// against a transaction-level model (grant choice, response countdown, arithmetic conversion).
module tb_gray_conv_sched;
    localparam int W = 4;
`ifdef GRAY_SCHED_FASTPATH_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 2;
`endif
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    gray_conv_sched_if #(.WIDTH(W)) bus();
    gray_conv_sched #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int checks = 0;
    int passes = 0;
    int glog[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [W-1:0] to_gray(input logic [W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [W-1:0] from_gray(input logic [W-1:0] g);
        logic [W-1:0] b = g;
        for (int s = 1; s < W; s <<= 1) b ^= b >> s;
        return b;
    endfunction

    function automatic logic [W-1:0] ref_conv(input logic mode, input logic [W-1:0] d);
        return mode ? from_gray(d) : to_gray(d);
    endfunction

    // model: idle or one transaction in flight, m_cnt edges since accept
    bit           m_busy = 1'b0;
    bit           m_last = 1'b1;
    int           m_cnt = 0;
    bit           m_id = 1'b0;
    logic [W-1:0] m_data = '0;

    function automatic int m_grant();
        if (m_busy || !rst_n) return -1;
        if (bus.req0_valid && bus.req1_valid) return m_last ? 0 : 1;
        if (bus.req0_valid) return 0;
        if (bus.req1_valid) return 1;
        return -1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 1'b0;
            m_last <= 1'b1;
            m_cnt  <= 0;
        end else if (!m_busy) begin
            if (m_grant() >= 0) begin
                m_busy <= 1'b1;
                m_cnt  <= 1;
                m_id   <= m_grant() == 1;
                m_last <= m_grant() == 1;
                m_data <= m_grant() == 1 ? ref_conv(bus.req1_mode, bus.req1_data)
                                         : ref_conv(bus.req0_mode, bus.req0_data);
            end
        end else if (m_cnt >= LAT) begin
            if (bus.rsp_ready) m_busy <= 1'b0;
        end else begin
            m_cnt <= m_cnt + 1;
        end
    end

    always @(negedge clk) begin
        chk("req0_ready", bus.req0_ready, m_grant() == 0);
        chk("req1_ready", bus.req1_ready, m_grant() == 1);
        chk("ready_excl", bus.req0_ready & bus.req1_ready, 0);
        chk("rsp_valid", bus.rsp_valid, m_busy && m_cnt >= LAT);
        chk("busy", bus.busy, m_busy);
        if (m_busy && m_cnt >= LAT) begin
            chk("rsp_id", bus.rsp_id, m_id);
            chk("rsp_data", bus.rsp_data, m_data);
        end
        if (bus.req0_ready) glog.push_back(0);
        if (bus.req1_ready) glog.push_back(1);
    end

    task automatic send(input bit id, input bit mode, input logic [W-1:0] d);
        bit got = 1'b0;
        @(posedge clk); #1;
        if (id) begin
            bus.req1_valid = 1'b1; bus.req1_mode = mode; bus.req1_data = d;
        end else begin
            bus.req0_valid = 1'b1; bus.req0_mode = mode; bus.req0_data = d;
        end
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            got = id ? bus.req1_ready : bus.req0_ready;
        end
        chk("accept_seen", got, 1);
        @(posedge clk); #1;
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        bus.req0_mode = 1'($urandom); bus.req1_mode = 1'($urandom);
        bus.req0_data = W'($urandom); bus.req1_data = W'($urandom);
    endtask

    task automatic wait_rsp(output int n, output logic id, output logic [W-1:0] d);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.rsp_valid && n < 20);
        chk("rsp_seen", bus.rsp_valid, 1);
        id = bus.rsp_id;
        d  = bus.rsp_data;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        logic id;
        logic [W-1:0] d, d0;
        logic id0;
        bus.req0_valid = 1'b1; bus.req0_mode = 1'b0; bus.req0_data = '0;
        bus.req1_valid = 1'b0; bus.req1_mode = 1'b0; bus.req1_data = '0;
        bus.rsp_ready = 1'b1;
        chk("pin_b2g_1111", to_gray(4'b1111), 4'b1000);
        chk("pin_g2b_1000", from_gray(4'b1000), 4'b1111);
        chk("pin_g2b_0110", from_gray(4'b0110), 4'b0100);
        chk("pin_b2g_0101", to_gray(4'b0101), 4'b0111);
        #1 rst_n = 1'b0;
        #2;
        chk("rst_req0_ready", bus.req0_ready, 0);
        chk("rst_req1_ready", bus.req1_ready, 0);
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_rsp_id", bus.rsp_id, 0);
        chk("rst_rsp_data", bus.rsp_data, 0);
        chk("rst_busy", bus.busy, 0);
        bus.req0_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        send(0, 0, 4'b1111);
        wait_rsp(n, id, d);
        chk("s1_latency", n, LAT);
        chk("s1_id", id, 0);
        chk("s1_data", d, 4'b1000);

        send(1, 1, 4'b1000);
        wait_rsp(n, id, d);
        chk("s2a_id", id, 1);
        chk("s2a_data", d, 4'b1111);
        send(1, 1, 4'b0110);
        wait_rsp(n, id, d);
        chk("s2b_data", d, 4'b0100);

        send(0, 0, 4'b0101);
        wait_rsp(n, id, d);
        chk("s3_latency", n, LAT);
        chk("s3_data", d, 4'b0111);

        // contested round robin straight after reset
        @(posedge clk); #1 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        glog.delete();
        bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
        for (int k = 0; k < 40 && glog.size() < 4; k++) begin
            @(negedge clk); #1;
        end
        @(posedge clk); #1;
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        chk("rr_count", glog.size(), 4);
        for (int i = 0; i < 4; i++) if (i < glog.size()) chk("rr_order", glog[i], i % 2);
        repeat (4) @(posedge clk);

        // stalled response with a competing request pending
        bus.rsp_ready = 1'b0;
        send(0, 1, 4'b1011);
        wait_rsp(n, id0, d0);
        chk("stall_data", d0, 4'b1101);
        repeat (5) begin
            @(posedge clk); #1 bus.req1_valid = 1'b1;
            @(negedge clk);
            chk("stall_valid", bus.rsp_valid, 1);
            chk("stall_id", bus.rsp_id, id0);
            chk("stall_data_hold", bus.rsp_data, d0);
            chk("stall_busy", bus.busy, 1);
            chk("stall_no_grant", bus.req0_ready | bus.req1_ready, 0);
        end
        @(posedge clk); #1;
        bus.rsp_ready = 1'b1; bus.req1_valid = 1'b0;

        // reset in the cycle after accept discards the conversion
        send(1, 0, 4'b0011);
        rst_n = 1'b0;
        #1;
        chk("mrst_rsp_valid", bus.rsp_valid, 0);
        chk("mrst_rsp_id", bus.rsp_id, 0);
        chk("mrst_rsp_data", bus.rsp_data, 0);
        chk("mrst_busy", bus.busy, 0);
        chk("mrst_ready", bus.req0_ready | bus.req1_ready, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("mrst_no_rsp", bus.rsp_valid, 0);
        end
        send(0, 1, 4'b1000);
        wait_rsp(n, id, d);
        chk("mrst_after_lat", n, LAT);
        chk("mrst_after_id", id, 0);
        chk("mrst_after_data", d, 4'b1111);

        for (int c = 0; c < 800; c++) begin
            @(posedge clk); #1;
            rst_n          = $urandom_range(0, 199) != 0;
            bus.req0_valid = $urandom_range(0, 2) != 0;
            bus.req1_valid = $urandom_range(0, 2) != 0;
            bus.req0_mode  = 1'($urandom);
            bus.req1_mode  = 1'($urandom);
            bus.req0_data  = W'($urandom);
            bus.req1_data  = W'($urandom);
            bus.rsp_ready  = $urandom_range(0, 9) < 7;
        end
        @(posedge clk); #1;
        rst_n = 1'b1; bus.req0_valid = 1'b0; bus.req1_valid = 1'b0; bus.rsp_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1 $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/gray_conv_sched.md
GRAY_CONV_SCHED -- requirements
Module: gray_conv_sched

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the code word width in bits (legal 2..16).
REQ-002 The block SHALL have port clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 The block SHALL have port req0_valid  input  1  requester 0 has a conversion pending.
REQ-005 The block SHALL have port req0_mode  input  1  requester 0 direction: 0 = binary->Gray, 1 = Gray->binary.
REQ-006 The block SHALL have port req0_data  input  WIDTH  requester 0 operand.
REQ-007 The block SHALL have port req0_ready  output  1  requester 0 operand accepted this cycle.
REQ-008 The block SHALL have ports req1_valid, req1_mode, req1_data and req1_ready, identical to REQ-004..007 for requester 1.
REQ-009 The block SHALL have port rsp_valid  output  1  rsp_id and rsp_data are valid.
REQ-010 The block SHALL have port rsp_id  output  1  index of the requester that owns the response.
REQ-011 The block SHALL have port rsp_data  output  WIDTH  converted word.
REQ-012 The block SHALL have port rsp_ready  input  1  consumer accepts the response.
REQ-013 The block SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-014 The FSM SHALL use the states IDLE, CONV and RESP, with exactly one conversion in flight at any time.
REQ-015 In IDLE, when any reqN_valid is high, the block SHALL grant one requester, assert its reqN_ready combinationally in that cycle, capture its mode, data and id on the clock edge, and move to CONV.
REQ-016 In IDLE, when neither request is valid, the block SHALL keep both ready signals low and stay in IDLE.
REQ-017 reqN_ready SHALL be high only in IDLE and only for the granted requester; both ready signals SHALL never be high together.
REQ-018 Arbitration SHALL be round-robin: with both requests valid, the grant SHALL go to the requester not granted last; a single valid request SHALL be granted regardless of the pointer.
REQ-019 The last-grant pointer SHALL update only when a grant is taken.
REQ-020 In CONV, the block SHALL register the result and move to RESP after one cycle.
REQ-021 Binary->Gray conversion SHALL compute g = b XOR (b >> 1).
REQ-022 Gray->binary conversion SHALL set b[MSB] = g[MSB] and b[i] = b[i+1] XOR g[i] for each lower bit.
REQ-023 In RESP, rsp_valid SHALL be high, and rsp_id and rsp_data SHALL stay stable until a cycle in which rsp_ready is high.
REQ-024 On that rsp_ready cycle, the block SHALL return to IDLE; no new grant SHALL be made in the same cycle, so the next grant occurs no earlier than the following cycle.
REQ-025 Latency SHALL be 2 clocks from the accept edge to rsp_valid high.
REQ-026 Peak throughput SHALL be one conversion per 3 cycles.
REQ-027 rsp_ready asserted outside RESP SHALL be ignored.
REQ-028 Changes on reqN_data or reqN_mode after the accept edge SHALL NOT affect the in-flight result.

Reset
REQ-029 While rst_n is low, the block SHALL force the FSM to IDLE and drive rsp_valid=0, rsp_id=0, rsp_data=0, busy=0, req0_ready=0 and req1_ready=0, with the pointer favouring requester 0 first.
REQ-030 Asserting rst_n mid-operation SHALL discard any in-flight conversion without producing a response.
REQ-031 After rst_n deasserts, the block SHALL make its first grant no earlier than the first rising edge.

Configuration
REQ-032 When GRAY_SCHED_FASTPATH_EN is defined, the CONV state SHALL be removed: the result SHALL be registered on the accept edge, giving 1-clock latency and peak throughput of one conversion per 2 cycles.
REQ-033 When GRAY_SCHED_FASTPATH_EN is undefined, the block SHALL behave exactly as REQ-014..028.
REQ-034 All ports and the handshake rules SHALL be identical in both builds.

Verification
REQ-035 Directed scenario: req0 mode=0 data=1111, rsp_ready=1 -> rsp_valid two cycles after the accept edge, rsp_id=0, rsp_data=1000.
REQ-036 Directed scenario: req1 mode=1 data=1000 -> rsp_id=1, rsp_data=1111; separately, mode=1 data=0110 -> rsp_data=0100.
REQ-037 Directed scenario: req0 and req1 held valid for 4 conversions after reset -> grant order 0,1,0,1, and never both ready high in the same cycle.
REQ-038 Directed scenario: rsp_ready held low 5 cycles in RESP -> rsp_valid, rsp_id and rsp_data stable throughout, no grants, busy=1.
REQ-039 Directed scenario: rst_n pulsed low during CONV -> all outputs 0 immediately, no response emitted, the next request served normally.
REQ-040 Directed scenario: GRAY_SCHED_FASTPATH_EN build, req0 mode=0 data=0101 -> rsp_data=0111 one cycle after the accept edge.
